// File: rtl/call_return_sequencer_if.sv
// Decoder, fetcher and data-RAM signals of the CALL/RET sequencer.
// The sequencer uses the slave modport; the master side drives strobes and returns RAM data.
interface call_return_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  call;
    logic                  ret;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] pc;
    logic [7:0]            ram_data_in;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [7:0]            ram_data_out;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] pc_set;
    logic                  branch;
    logic [ADDR_WIDTH-1:0] sp;
    logic                  stack_fault;

    modport master (
        output call, ret, target, pc, ram_data_in,
        input  busy, done, ram_addr, ram_data_out, ram_we, ram_re, pc_set, branch, sp,
               stack_fault
    );

    modport slave (
        input  call, ret, target, pc, ram_data_in,
        output busy, done, ram_addr, ram_data_out, ram_we, ram_re, pc_set, branch, sp,
               stack_fault
    );
endinterface

// File: rtl/call_return_sequencer.sv
// Multi-cycle CALL/RET executor: pushes or pops a 16-bit return address on an upward-growing
// byte stack in data RAM and redirects the fetcher. Every output is registered per state.
module call_return_sequencer #(
    parameter int unsigned          ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] SP_RESET    = 16'h00FF,
    parameter logic [ADDR_WIDTH-1:0] STACK_LIMIT = 16'h01FF
) (
    input logic                    clk_i,
    input logic                    rst_i,
    call_return_sequencer_if.slave bus_io
);
    typedef enum logic [2:0] {
        StIdle, StPushLo, StPushHi, StPopHi, StPopLo, StPopWait, StJump, StFault
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] One    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] Two    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] PopMin = SP_RESET + Two;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] sp_q;
    logic                  fault_q;
    logic [ADDR_WIDTH-1:0] ret_addr_q;
    logic [ADDR_WIDTH-1:0] target_q;
    logic [7:0]            hi_q;
    logic                  busy_q, done_q, we_q, re_q, branch_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            dout_q;
    logic [ADDR_WIDTH-1:0] pc_set_q;

    // One extra bit so the overflow compare cannot itself wrap.
    logic [ADDR_WIDTH:0]   sp_push_end;
    logic                  push_ovf;
    logic                  pop_unf;
    logic [ADDR_WIDTH-1:0] pc_next;

    assign sp_push_end = {1'b0, sp_q} + {1'b0, Two};
    assign push_ovf    = sp_push_end > {1'b0, STACK_LIMIT};
    assign pop_unf     = sp_q < PopMin;
    assign pc_next     = bus_io.pc + One;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            sp_q       <= SP_RESET;
            fault_q    <= 1'b0;
            ret_addr_q <= '0;
            target_q   <= '0;
            hi_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            branch_q   <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
            pc_set_q   <= '0;
        end else begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            branch_q <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            pc_set_q <= '0;
            unique case (state_q)
                StIdle: begin
                    // Call has priority; a simultaneous Ret is dropped.
                    if (bus_io.call) begin
                        busy_q <= 1'b1;
                        if (push_ovf) begin
                            state_q <= StFault;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else begin
                            state_q    <= StPushLo;
                            ret_addr_q <= pc_next;
                            target_q   <= bus_io.target;
                            we_q       <= 1'b1;
                            addr_q     <= sp_q + One;
                            dout_q     <= pc_next[7:0];
                        end
                    end else if (bus_io.ret) begin
                        busy_q <= 1'b1;
                        if (pop_unf) begin
                            state_q <= StFault;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= StPopHi;
                            re_q    <= 1'b1;
                            addr_q  <= sp_q;
                        end
                    end
                end
                StPushLo: begin
                    state_q <= StPushHi;
                    sp_q    <= sp_q + One;
                    busy_q  <= 1'b1;
                    we_q    <= 1'b1;
                    addr_q  <= sp_q + Two;
                    dout_q  <= ret_addr_q[15:8];
                end
                StPushHi: begin
                    state_q  <= StJump;
                    sp_q     <= sp_q + One;
                    busy_q   <= 1'b1;
                    done_q   <= 1'b1;
                    branch_q <= 1'b1;
                    pc_set_q <= target_q;
                end
                StPopHi: begin
                    state_q <= StPopLo;
                    busy_q  <= 1'b1;
                    re_q    <= 1'b1;
                    addr_q  <= sp_q - One;
                end
                StPopLo: begin
                    state_q <= StPopWait;
                    hi_q    <= bus_io.ram_data_in;
                    busy_q  <= 1'b1;
                end
                StPopWait: begin
                    state_q  <= StJump;
                    sp_q     <= sp_q - Two;
                    busy_q   <= 1'b1;
                    done_q   <= 1'b1;
                    branch_q <= 1'b1;
                    pc_set_q <= {hi_q, bus_io.ram_data_in};
                end
                StJump:  state_q <= StIdle;
                StFault: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.busy         = busy_q;
    assign bus_io.done         = done_q;
    assign bus_io.ram_we       = we_q;
    assign bus_io.ram_re       = re_q;
    assign bus_io.branch       = branch_q;
    assign bus_io.ram_addr     = addr_q;
    assign bus_io.ram_data_out = dout_q;
    assign bus_io.pc_set       = pc_set_q;
    assign bus_io.sp           = sp_q;
    assign bus_io.stack_fault  = fault_q;
endmodule

// File: tb/tb_call_return_sequencer.sv
// Directed bench for call_return_sequencer with a byte RAM model answering reads one cycle late.
module tb_call_return_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    call_return_sequencer_if bus ();

    call_return_sequencer dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    logic [7:0] rdata = 8'h00;

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data_out;
        if (bus.ram_re) rdata <= mem[bus.ram_addr];
    end
    assign bus.ram_data_in = rdata;

    // {busy, done, ram_we, ram_re, branch}
    function automatic logic [4:0] st();
        return {bus.busy, bus.done, bus.ram_we, bus.ram_re, bus.branch};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.call = 1'b0; bus.ret = 1'b0; bus.pc = '0; bus.target = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.call = 1'b0; bus.ret = 1'b0; bus.pc = '0; bus.target = '0;
        tick(); tick();
        n_cmp++; if (st() !== 5'b00000) begin n_err++; $display("FAIL reset_status got %b exp 00000", st()); end
        n_cmp++; if (bus.sp !== 16'h00FF) begin n_err++; $display("FAIL reset_sp got %h exp 00ff", bus.sp); end
        n_cmp++; if (bus.stack_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b exp 0", bus.stack_fault); end
        n_cmp++; if ({bus.ram_addr, bus.ram_data_out, bus.pc_set} !== 40'h0) begin n_err++; $display("FAIL reset_buses got %h exp 0", {bus.ram_addr, bus.ram_data_out, bus.pc_set}); end
        rst = 1'b0;
        tick();
        n_cmp++; if (st() !== 5'b00000) begin n_err++; $display("FAIL reset_idle got %b exp 00000", st()); end
    endtask

    task automatic test_call();
        bus.pc = 16'h0010; bus.target = 16'h0200; bus.call = 1'b1;
        tick();
        bus.call = 1'b0;
        n_cmp++; if (st() !== 5'b10100) begin n_err++; $display("FAIL call_c1_status got %b exp 10100", st()); end
        n_cmp++; if ({bus.ram_addr, bus.ram_data_out} !== 24'h0100_11) begin n_err++; $display("FAIL call_c1_write got %h exp 010011", {bus.ram_addr, bus.ram_data_out}); end
        n_cmp++; if (bus.sp !== 16'h00FF) begin n_err++; $display("FAIL call_c1_sp got %h exp 00ff", bus.sp); end
        tick();
        n_cmp++; if (st() !== 5'b10100) begin n_err++; $display("FAIL call_c2_status got %b exp 10100", st()); end
        n_cmp++; if ({bus.ram_addr, bus.ram_data_out} !== 24'h0101_00) begin n_err++; $display("FAIL call_c2_write got %h exp 010100", {bus.ram_addr, bus.ram_data_out}); end
        n_cmp++; if (bus.sp !== 16'h0100) begin n_err++; $display("FAIL call_c2_sp got %h exp 0100", bus.sp); end
        tick();
        n_cmp++; if (st() !== 5'b11001) begin n_err++; $display("FAIL call_c3_status got %b exp 11001", st()); end
        n_cmp++; if (bus.pc_set !== 16'h0200) begin n_err++; $display("FAIL call_c3_pcset got %h exp 0200", bus.pc_set); end
        n_cmp++; if (bus.sp !== 16'h0101) begin n_err++; $display("FAIL call_c3_sp got %h exp 0101", bus.sp); end
        tick();
        n_cmp++; if (st() !== 5'b00000) begin n_err++; $display("FAIL call_c4_idle got %b exp 00000", st()); end
        n_cmp++; if ({mem[16'h0100], mem[16'h0101]} !== 16'h1100) begin n_err++; $display("FAIL call_ram got %h exp 1100", {mem[16'h0100], mem[16'h0101]}); end
    endtask

    task automatic test_ret();
        bus.ret = 1'b1;
        tick();
        bus.ret = 1'b0;
        n_cmp++; if (st() !== 5'b10010) begin n_err++; $display("FAIL ret_c1_status got %b exp 10010", st()); end
        n_cmp++; if (bus.ram_addr !== 16'h0101) begin n_err++; $display("FAIL ret_c1_addr got %h exp 0101", bus.ram_addr); end
        tick();
        n_cmp++; if (st() !== 5'b10010) begin n_err++; $display("FAIL ret_c2_status got %b exp 10010", st()); end
        n_cmp++; if (bus.ram_addr !== 16'h0100) begin n_err++; $display("FAIL ret_c2_addr got %h exp 0100", bus.ram_addr); end
        tick();
        n_cmp++; if (st() !== 5'b10000) begin n_err++; $display("FAIL ret_c3_status got %b exp 10000", st()); end
        tick();
        n_cmp++; if (st() !== 5'b11001) begin n_err++; $display("FAIL ret_c4_status got %b exp 11001", st()); end
        n_cmp++; if (bus.pc_set !== 16'h0011) begin n_err++; $display("FAIL ret_c4_pcset got %h exp 0011", bus.pc_set); end
        n_cmp++; if (bus.sp !== 16'h00FF) begin n_err++; $display("FAIL ret_c4_sp got %h exp 00ff", bus.sp); end
        tick();
        n_cmp++; if (st() !== 5'b00000) begin n_err++; $display("FAIL ret_c5_idle got %b exp 00000", st()); end
    endtask

    task automatic test_underflow();
        do_reset();
        bus.ret = 1'b1;
        tick();
        bus.ret = 1'b0;
        n_cmp++; if (st() !== 5'b11000) begin n_err++; $display("FAIL unf_c1_status got %b exp 11000", st()); end
        n_cmp++; if ({bus.stack_fault, bus.sp} !== 17'h1_00FF) begin n_err++; $display("FAIL unf_c1_fault_sp got %h exp 100ff", {bus.stack_fault, bus.sp}); end
        tick();
        n_cmp++; if (st() !== 5'b00000) begin n_err++; $display("FAIL unf_c2_idle got %b exp 00000", st()); end
        bus.pc = 16'h1234; bus.target = 16'h4000; bus.call = 1'b1;
        tick();
        bus.call = 1'b0;
        n_cmp++; if ({bus.ram_addr, bus.ram_data_out} !== 24'h0100_35) begin n_err++; $display("FAIL unf_call_lo got %h exp 010035", {bus.ram_addr, bus.ram_data_out}); end
        tick(); tick();
        n_cmp++; if (st() !== 5'b11001) begin n_err++; $display("FAIL unf_call_status got %b exp 11001", st()); end
        n_cmp++; if (bus.pc_set !== 16'h4000) begin n_err++; $display("FAIL unf_call_pcset got %h exp 4000", bus.pc_set); end
        tick();
        n_cmp++; if (bus.stack_fault !== 1'b1) begin n_err++; $display("FAIL unf_sticky got %b exp 1", bus.stack_fault); end
    endtask

    task automatic test_nested();
        do_reset();
        for (int i = 0; i < 128; i++) begin
            bus.pc = 16'(i); bus.target = 16'(i + 16'h1000); bus.call = 1'b1;
            tick();
            bus.call = 1'b0;
            tick(); tick(); tick();
        end
        n_cmp++; if (bus.sp !== 16'h01FF) begin n_err++; $display("FAIL nest_sp got %h exp 01ff", bus.sp); end
        n_cmp++; if (bus.stack_fault !== 1'b0) begin n_err++; $display("FAIL nest_fault got %b exp 0", bus.stack_fault); end
        n_cmp++; if ({mem[16'h01FE], mem[16'h01FF]} !== 16'h8000) begin n_err++; $display("FAIL nest_top got %h exp 8000", {mem[16'h01FE], mem[16'h01FF]}); end
        bus.pc = 16'h0500; bus.call = 1'b1;
        tick();
        bus.call = 1'b0;
        n_cmp++; if (st() !== 5'b11000) begin n_err++; $display("FAIL ovf_status got %b exp 11000", st()); end
        n_cmp++; if ({bus.stack_fault, bus.sp} !== 17'h1_01FF) begin n_err++; $display("FAIL ovf_fault_sp got %h exp 101ff", {bus.stack_fault, bus.sp}); end
        tick();
        n_cmp++; if ({st(), bus.sp} !== 21'h0_01FF) begin n_err++; $display("FAIL ovf_after got %h exp 001ff", {st(), bus.sp}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.pc = 16'hFFFF; bus.target = 16'h0300; bus.call = 1'b1; bus.ret = 1'b1;
        tick();
        bus.ret = 1'b0;
        n_cmp++; if (st() !== 5'b10100) begin n_err++; $display("FAIL both_c1_status got %b exp 10100", st()); end
        n_cmp++; if ({bus.ram_addr, bus.ram_data_out} !== 24'h0100_00) begin n_err++; $display("FAIL wrap_lo got %h exp 010000", {bus.ram_addr, bus.ram_data_out}); end
        tick();
        n_cmp++; if ({bus.ram_addr, bus.ram_data_out} !== 24'h0101_00) begin n_err++; $display("FAIL wrap_hi got %h exp 010100", {bus.ram_addr, bus.ram_data_out}); end
        tick();
        n_cmp++; if ({st(), bus.pc_set} !== 21'h19_0300) begin n_err++; $display("FAIL busy_jump got %h exp 190300", {st(), bus.pc_set}); end
        bus.call = 1'b0;
        tick();
        n_cmp++; if ({st(), bus.sp} !== 21'h0_0101) begin n_err++; $display("FAIL busy_ignored got %h exp 00101", {st(), bus.sp}); end
        tick();
        n_cmp++; if (st() !== 5'b00000) begin n_err++; $display("FAIL busy_idle got %b exp 00000", st()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.pc = 16'h0010; bus.target = 16'h0200; bus.call = 1'b1;
        tick();
        bus.call = 1'b0;
        tick();
        n_cmp++; if ({st(), bus.ram_addr} !== 21'h14_0101) begin n_err++; $display("FAIL mid_pushhi got %h exp 140101", {st(), bus.ram_addr}); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({st(), bus.ram_addr, bus.ram_data_out, bus.pc_set} !== 45'h0) begin n_err++; $display("FAIL mid_async_outs got %h exp 0", {st(), bus.ram_addr, bus.ram_data_out, bus.pc_set}); end
        n_cmp++; if ({bus.stack_fault, bus.sp} !== 17'h0_00FF) begin n_err++; $display("FAIL mid_async_sp got %h exp 000ff", {bus.stack_fault, bus.sp}); end
        tick();
        rst = 1'b0;
        n_cmp++; if (st() !== 5'b00000) begin n_err++; $display("FAIL mid_held got %b exp 00000", st()); end
        tick();
        n_cmp++; if ({st(), bus.sp} !== 21'h0_00FF) begin n_err++; $display("FAIL mid_release got %h exp 000ff", {st(), bus.sp}); end
        bus.call = 1'b1;
        tick();
        bus.call = 1'b0;
        tick(); tick();
        n_cmp++; if ({st(), bus.pc_set, bus.sp} !== 37'h19_0200_0101) begin n_err++; $display("FAIL mid_recall got %h exp 1902000101", {st(), bus.pc_set, bus.sp}); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_call();
        test_ret();
        test_underflow();
        test_nested();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
